// File: rtl/uart_cmd_receiver.sv
// uart_cmd_receiver
//   Host-link front end. Deserialises the host UART line into bytes and buffers
//   them in a show-ahead FIFO that feeds the command decoder over a
//   valid/ready byte stream. Reports dropped bytes and bad stop bits.
//
//   Frame format: 8N1 by default. Defining UART_CMD_PARITY_EN selects 8E1 and
//   adds the parity_err_count port.
//
// Parameters
//   CLK_HZ      system clock frequency
//   BAUD        line rate; CLK_HZ/BAUD must be >= 4
//   FIFO_DEPTH  byte FIFO entries; power of two, >= 2
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   uart_rx            asynchronous serial line, idles high
//   cmd_in_valid       FIFO head byte is valid
//   cmd_in_ready       consumer accepts the head byte
//   cmd_in_data        FIFO head byte (0 while empty)
//   fifo_level         registered occupancy, 0..FIFO_DEPTH
//   overflow           sticky: a byte was dropped because the FIFO was full
//   framing_err_count  saturating count of bad stop bits
//   parity_err_count   saturating count of parity mismatches (parity build only)
//   clear_errors       pulse; clears overflow and the error counters
module uart_cmd_receiver #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        uart_rx,
  output logic                        cmd_in_valid,
  input  logic                        cmd_in_ready,
  output logic [7:0]                  cmd_in_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [7:0]                  framing_err_count,
`ifdef UART_CMD_PARITY_EN
  output logic [7:0]                  parity_err_count,
`endif
  input  logic                        clear_errors
);

  typedef logic [7:0] byte_t;

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam int unsigned TW           = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] BIT_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_LEVEL = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_CMD_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchroniser; rx_d is the previous rx_s for falling-edge detection.
  // ---------------------------------------------------------------------------
  logic rx_m, rx_s, rx_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  byte_t         shift, shift_nxt;
  logic          push_req;
  logic          ferr_inc;
  logic          par_ok;
`ifdef UART_CMD_PARITY_EN
  logic          par_ok_nxt;
  logic          perr_inc;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

`ifdef UART_CMD_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) par_ok <= 1'b1;
    else       par_ok <= par_ok_nxt;
  end
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 1'b1;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    push_req  = 1'b0;
    ferr_inc  = 1'b0;
`ifdef UART_CMD_PARITY_EN
    par_ok_nxt = par_ok;
    perr_inc   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        timer_nxt = '0;
        if (rx_d && !rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (timer == HALF_LAST) begin
          timer_nxt = '0;
          if (!rx_s) begin
            state_nxt = S_DATA;
            bit_nxt   = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (timer == BIT_LAST) begin
          timer_nxt = '0;
          shift_nxt = {rx_s, shift[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_CMD_PARITY_EN
      S_PARITY: begin
        if (timer == BIT_LAST) begin
          timer_nxt  = '0;
          state_nxt  = S_STOP;
          par_ok_nxt = (rx_s == ^shift);
          perr_inc   = (rx_s != ^shift);
        end
      end
`endif
      S_STOP: begin
        if (timer == BIT_LAST) begin
          timer_nxt = '0;
          if (rx_s) begin
            push_req  = par_ok;
            state_nxt = S_IDLE;
          end else begin
            ferr_inc  = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        timer_nxt = '0;
        if (rx_s) state_nxt = S_IDLE;
      end
      default: begin
        timer_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Show-ahead byte FIFO
  // ---------------------------------------------------------------------------
  byte_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, full, do_push;

  assign cmd_in_valid = (fifo_level != '0);
  assign cmd_in_data  = cmd_in_valid ? mem[rd_ptr] : '0;
  assign pop          = cmd_in_valid && cmd_in_ready;
  assign full         = (fifo_level == FULL_LEVEL);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign do_push      = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !do_push) fifo_level <= fifo_level - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Error reporting; clear_errors wins over a same-cycle set or increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow          <= 1'b0;
      framing_err_count <= '0;
    end else if (clear_errors) begin
      overflow          <= 1'b0;
      framing_err_count <= '0;
    end else begin
      if (push_req && full && !pop) overflow <= 1'b1;
      if (ferr_inc && framing_err_count != 8'hFF)
        framing_err_count <= framing_err_count + 8'd1;
    end
  end

`ifdef UART_CMD_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn || clear_errors) begin
      parity_err_count <= '0;
    end else if (perr_inc && parity_err_count != 8'hFF) begin
      parity_err_count <= parity_err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Directed testbench for uart_cmd_receiver at 10 clocks per bit, 16-entry FIFO.
module tb_uart_cmd_receiver;

  logic       clk = 1'b0;
  logic       rstn;
  logic       uart_rx;
  logic       cmd_in_valid;
  logic       cmd_in_ready;
  logic [7:0] cmd_in_data;
  logic [4:0] fifo_level;
  logic       overflow;
  logic [7:0] framing_err_count;
  logic       clear_errors;
`ifdef UART_CMD_PARITY_EN
  logic [7:0] parity_err_count;
`endif

  int checks = 0;
  int errors = 0;

  uart_cmd_receiver #(
    .CLK_HZ    (1000000),
    .BAUD      (100000),
    .FIFO_DEPTH(16)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .uart_rx          (uart_rx),
    .cmd_in_valid     (cmd_in_valid),
    .cmd_in_ready     (cmd_in_ready),
    .cmd_in_data      (cmd_in_data),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .framing_err_count(framing_err_count),
`ifdef UART_CMD_PARITY_EN
    .parity_err_count (parity_err_count),
`endif
    .clear_errors     (clear_errors)
  );

  always #5 clk = ~clk;

  // Every drive and sample happens 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first (and parity bit if enabled), 10 clocks each.
  task automatic drive_head(input logic [7:0] d);
    uart_rx = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (10) tick();
    end
`ifdef UART_CMD_PARITY_EN
    uart_rx = ^d;
    repeat (10) tick();
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_head(d);
    uart_rx = stop;
    repeat (10) tick();
    if (stop) repeat (2) tick();
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
  endtask

  initial begin
    logic [7:0] t1_bytes [2];
    t1_bytes[0] = 8'hA0;
    t1_bytes[1] = 8'h05;

    // Reset state
    rstn = 1'b0; uart_rx = 1'b1; cmd_in_ready = 1'b0; clear_errors = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(cmd_in_valid), 0);
    check("rst_data", 32'(cmd_in_data), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_ferr", 32'(framing_err_count), 0);
    rstn = 1'b1;
    repeat (5) tick();

    // Two bytes with ready high; valid rises one cycle after the stop sample
    cmd_in_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      drive_head(t1_bytes[b]);
      uart_rx = 1'b1;
      repeat (7) tick();
      check("t1_valid_before_stop", 32'(cmd_in_valid), 0);
      tick();
      check("t1_valid_after_stop", 32'(cmd_in_valid), 1);
      check("t1_data", 32'(cmd_in_data), 32'(t1_bytes[b]));
      check("t1_level_one", 32'(fifo_level), 1);
      tick();
      check("t1_popped", 32'(cmd_in_valid), 0);
      repeat (4) tick();
    end
    check("t1_level_zero", 32'(fifo_level), 0);

    // Overflow: 17 bytes into a 16-entry FIFO with ready low
    cmd_in_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    check("t2_level_full", 32'(fifo_level), 16);
    check("t2_no_overflow_yet", 32'(overflow), 0);
    send_frame(8'h10, 1'b1);
    check("t2_level_still_full", 32'(fifo_level), 16);
    check("t2_overflow", 32'(overflow), 1);
    cmd_in_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain_valid", 32'(cmd_in_valid), 1);
      check("t2_drain_data", 32'(cmd_in_data), 32'(i));
      tick();
    end
    cmd_in_ready = 1'b0;
    check("t2_empty_valid", 32'(cmd_in_valid), 0);
    check("t2_empty_level", 32'(fifo_level), 0);
    pulse_clear();
    check("t2_overflow_cleared", 32'(overflow), 0);

    // Framing error on 0x55, long low counts once, then 0x3C
    send_frame(8'h55, 1'b0);
    check("t3_ferr", 32'(framing_err_count), 1);
    check("t3_no_push", 32'(fifo_level), 0);
    repeat (50) tick();
    check("t3_ferr_once", 32'(framing_err_count), 1);
    check("t3_still_empty", 32'(fifo_level), 0);
    uart_rx = 1'b1;
    repeat (5) tick();
    send_frame(8'h3C, 1'b1);
    check("t3_next_level", 32'(fifo_level), 1);
    check("t3_next_data", 32'(cmd_in_data), 32'h3C);
    check("t3_ferr_unchanged", 32'(framing_err_count), 1);
    cmd_in_ready = 1'b1; tick(); cmd_in_ready = 1'b0;

    // 3-cycle glitch on idle line
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    check("t4_glitch_no_push", 32'(fifo_level), 0);
    check("t4_glitch_no_err", 32'(framing_err_count), 1);
    send_frame(8'h81, 1'b1);
    check("t4_after_glitch_data", 32'(cmd_in_data), 32'h81);
    check("t4_after_glitch_level", 32'(fifo_level), 1);
    cmd_in_ready = 1'b1; tick(); cmd_in_ready = 1'b0;
    pulse_clear();
    check("t4_ferr_cleared", 32'(framing_err_count), 0);

    // Full FIFO with a pop on the exact stop-sample cycle
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1);
    check("t5_full", 32'(fifo_level), 16);
    drive_head(8'h77);
    uart_rx = 1'b1;
    repeat (7) tick();
    cmd_in_ready = 1'b1;
    tick();
    cmd_in_ready = 1'b0;
    check("t5_level_same", 32'(fifo_level), 16);
    check("t5_no_overflow", 32'(overflow), 0);
    check("t5_head_advanced", 32'(cmd_in_data), 32'h21);
    repeat (4) tick();
    cmd_in_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("t5_drain", 32'(cmd_in_data), 32'h20 + 32'(i));
      tick();
    end
    check("t5_last_byte", 32'(cmd_in_data), 32'h77);
    tick();
    cmd_in_ready = 1'b0;
    check("t5_empty", 32'(fifo_level), 0);

    // Reset mid-frame with 4 bytes buffered
    for (int i = 0; i < 4; i++) send_frame(8'h40 + 8'(i), 1'b1);
    check("t6_buffered", 32'(fifo_level), 4);
    uart_rx = 1'b0;
    repeat (10) tick();
    uart_rx = 1'b1;
    repeat (10) tick();
    rstn = 1'b0;
    tick();
    check("t6_rst_valid", 32'(cmd_in_valid), 0);
    check("t6_rst_level", 32'(fifo_level), 0);
    check("t6_rst_data", 32'(cmd_in_data), 0);
    rstn = 1'b1;
    uart_rx = 1'b1;
    repeat (120) tick();
    check("t6_no_spurious", 32'(fifo_level), 0);
    send_frame(8'hB0, 1'b1);
    check("t6_after_valid", 32'(cmd_in_valid), 1);
    check("t6_after_level", 32'(fifo_level), 1);
    check("t6_after_data", 32'(cmd_in_data), 32'hB0);
    check("t6_after_ferr", 32'(framing_err_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
